// File: rtl/pipe_pkg.sv
// Shared types and sideband reset defaults for inter-stage pipeline buffers.
// Skid FSM encoding is only used when PIPE_SKID_EN is defined.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } skid_state_t;

  typedef logic [1:0] occ_t;

  localparam int DATA_W_DEF = 32;
  localparam int CTRL_W_DEF = 8;

  // Per-stage sideband idle encodings (regfilemux selects alu_out = 0)
  localparam logic [7:0] CTRL_RST_IFID  = 8'h00;
  localparam logic [7:0] CTRL_RST_IDEX  = 8'h00;
  localparam logic [7:0] CTRL_RST_EXMEM = 8'h00;
  localparam logic [7:0] CTRL_RST_MEMWB = 8'h00;

  function automatic occ_t occ_of(skid_state_t s);
    occ_t o;
    unique case (s)
      EMPTY:   o = 2'd0;
      BUSY:    o = 2'd1;
      FULL:    o = 2'd2;
      default: o = 2'd0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One storage slot of a pipeline buffer: payload plus sideband word.
// Loads on ld, otherwise holds; asynchronous active-low reset.
module pipe_slot #(
  parameter int            W       = 40,
  parameter logic [W-1:0]  RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] word_q;
  logic [W-1:0] word_d;

  always_comb begin
    word_d = word_q;
    if (ld) begin
      word_d = d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word_q <= RST_VAL;
    end else begin
      word_q <= word_d;
    end
  end

  assign q = word_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// Inter-stage pipeline buffer with valid/ready, flush and bubble support.
// PIPE_SKID_EN selects a 2-slot skid with registered in_ready.
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int                 DATA_W   = 32,
  parameter int                 CTRL_W   = 8,
  parameter logic [CTRL_W-1:0]  CTRL_RST = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);

  localparam int W = DATA_W + CTRL_W;
  localparam logic [W-1:0] SLOT_RST = {{DATA_W{1'b0}}, CTRL_RST};

  logic [W-1:0] in_word;
  logic [W-1:0] main_q;
  logic [W-1:0] main_din;
  logic         main_ld;
  logic         valid;
  logic         accept;
  logic         consume;

  assign in_word = {in_data, in_ctrl};

`ifdef PIPE_SKID_EN
  skid_state_t  state_q;
  skid_state_t  state_d;
  logic         in_ready_q;
  logic         in_ready_d;
  logic         skid_ld;
  logic [W-1:0] skid_q;

  assign valid    = (state_q != EMPTY);
  assign in_ready = in_ready_q;
  assign accept   = in_valid & in_ready_q;
  assign consume  = valid & out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: if (accept) state_d = BUSY;
        BUSY: begin
          if (accept && !consume) begin
            state_d = FULL;
          end else if (!accept && consume) begin
            state_d = EMPTY;
          end
        end
        FULL: if (consume) state_d = BUSY;
        default: state_d = EMPTY;
      endcase
    end
  end

  // in_ready is precomputed from next state so no out_ready path reaches it
  always_comb begin
    main_ld    = 1'b0;
    skid_ld    = 1'b0;
    main_din   = in_word;
    in_ready_d = (state_d != FULL);
    if (!flush) begin
      unique case (state_q)
        EMPTY: main_ld = accept;
        BUSY: begin
          main_ld = accept & consume;
          skid_ld = accept & ~consume;
        end
        FULL: begin
          main_ld  = consume;
          main_din = skid_q;
        end
        default: ;
      endcase
    end
  end

  assign occupancy = occ_of(state_q);

  pipe_slot #(
    .W       (W),
    .RST_VAL (SLOT_RST)
  ) u_skid (
    .clk (clk),
    .rst (rst),
    .ld  (skid_ld),
    .d   (in_word),
    .q   (skid_q)
  );
`else
  logic valid_q;
  logic valid_d;

  assign valid    = valid_q;
  assign in_ready = ~valid_q | out_ready;
  assign accept   = in_valid & in_ready;
  assign consume  = valid_q & out_ready;

  always_comb begin
    valid_d = valid_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
    end else if (consume) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
    end
  end

  assign main_ld   = accept & ~flush;
  assign main_din  = in_word;
  assign occupancy = {1'b0, valid_q};
`endif

  pipe_slot #(
    .W       (W),
    .RST_VAL (SLOT_RST)
  ) u_main (
    .clk (clk),
    .rst (rst),
    .ld  (main_ld),
    .d   (main_din),
    .q   (main_q)
  );

  assign out_valid = valid;
  assign out_data  = main_q[W-1:CTRL_W];
  assign out_ctrl  = valid ? main_q[CTRL_W-1:0] : CTRL_RST;

endmodule
